tpu_sequencer: RTL and testbench
================================

TPU_SEQUENCER -- requirements
Module: tpu_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: systolic array rows, i.e. weight rows loaded per job.
REQ-002 SHALL have parameter NUM_OP, default 10: activation vectors streamed per job.
REQ-003 SHALL have parameter PISO_FULL, default 8: result beats drained per job.
REQ-004 SHALL have parameter COUNT_WIDTH, default 4: width of all index outputs and the internal phase counter.
REQ-005 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1: job request, sampled only in IDLE.
REQ-008 SHALL have port abort, input, 1: synchronous job cancel.
REQ-009 SHALL have port stall, input, 1: freeze LOAD_W/COMPUTE progress.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts a drain beat.
REQ-011 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-012 SHALL have port done, output, 1: one-cycle job-complete pulse.
REQ-013 SHALL have ports w_load (output, 1) and w_row (output, COUNT_WIDTH): weight-row write strobe and row index.
REQ-014 SHALL have ports a_valid (output, 1) and a_idx (output, COUNT_WIDTH): activation strobe and vector index.
REQ-015 SHALL have ports acc_clr (output, 1) and piso_load (output, 1): accumulator clear pulse and PISO parallel-load pulse.
REQ-016 SHALL have port out_valid, output, 1: drain beat valid.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD_W, COMPUTE, DRAIN and DONE, using one shared phase counter that is cleared on every state change.
REQ-018 SHALL, in IDLE with start=1 and abort=0, go to LOAD_W on the next cycle; start in any other state SHALL be ignored.
REQ-019 SHALL, in LOAD_W, assert w_load=1 with w_row=counter; when stall=0 the counter increments; at counter==DEPTH-1 with stall=0 the FSM goes to COMPUTE.
REQ-020 SHALL assert acc_clr for exactly the first cycle of COMPUTE.
REQ-021 SHALL, in COMPUTE, assert a_valid=1 and a_idx=counter while counter<NUM_OP; the total phase is NUM_OP+DEPTH-1 non-stalled cycles, covering skew flush.
REQ-022 SHALL assert piso_load on the last non-stalled COMPUTE cycle, after which the FSM goes to DRAIN.
REQ-023 SHALL, in DRAIN, hold out_valid=1; a beat completes when out_ready=1; the counter increments per beat; the FSM goes to DONE after beat PISO_FULL-1. stall SHALL NOT affect DRAIN.
REQ-024 SHALL, in DONE, assert done=1 for one cycle and then return to IDLE unconditionally.
REQ-025 SHALL, when stall=1, hold the counter, state and all strobe values; acc_clr and piso_load SHALL NOT re-fire and SHALL be suppressed while stalled.
REQ-026 SHALL, when abort=1 in any state, enter IDLE on the next cycle with counter=0 and no done pulse; abort SHALL win over start, stall and completion.
REQ-027 SHALL deassert w_load, a_valid, out_valid, acc_clr and piso_load, and drive w_row and a_idx to 0, outside their respective phases.
REQ-028 SHALL compare against the counter at COUNT_WIDTH width; COUNT_WIDTH SHALL be at least clog2(max(DEPTH, NUM_OP+DEPTH-1, PISO_FULL)), and this SHALL be checked by elaboration assertion.

Reset
REQ-029 SHALL, on rst_n=0, immediately (asynchronously) force state IDLE and counter 0, with every output at 0.
REQ-030 SHALL, on reset mid-job, discard the job entirely; the first cycle after release is IDLE.

Configuration
REQ-031 SHALL, when macro TPU_SEQ_WEIGHT_REUSE_EN is defined, add input reuse_w (1 bit); start with reuse_w=1 SHALL go IDLE->COMPUTE directly, skipping LOAD_W.
REQ-032 SHALL, when TPU_SEQ_WEIGHT_REUSE_EN is undefined, have no reuse_w port and always execute LOAD_W.

Structure
REQ-033 SHALL take the state enum type (seq_state_t) from shared package tpu_pkg.
REQ-034 SHALL contain one sub-module, tpu_phase_counter: a loadable up-counter with enable, sync clear and terminal-count compare.

Verification
REQ-035 SHALL cover a nominal job: defaults, start pulse, no stall, out_ready=1 -> w_load for 4 cycles (w_row 0..3); a_valid for 10 cycles (a_idx 0..9); COMPUTE lasts 13 cycles; out_valid for 8 cycles; done exactly 1 cycle after the last beat; 27 busy cycles total.
REQ-036 SHALL cover stall: stall=1 for 3 cycles at LOAD_W row 2 -> w_row holds 2 for 4 cycles and the job lengthens by exactly 3 cycles.
REQ-037 SHALL cover backpressure: out_ready toggling 1,0,1,0 -> exactly 8 accepted beats, and done only after the 8th accepted beat.
REQ-038 SHALL cover abort: abort in COMPUTE at a_idx=5 -> IDLE next cycle, busy=0 and done never asserted; then start with abort=1 in IDLE -> the FSM stays in IDLE.
REQ-039 SHALL cover reset: rst_n low mid-DRAIN -> all outputs 0 with no clock edge needed; after release a new start runs a full nominal job.
REQ-040 SHALL cover reuse with TPU_SEQ_WEIGHT_REUSE_EN defined: start with reuse_w=1 -> no w_load, acc_clr on the cycle after start, and 23 busy cycles total.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU sequencer slice: the FSM state encoding
// and a constant-friendly max used when sizing the phase counter.
package tpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_COMPUTE,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tpu_phase_counter.sv
// Loadable up-counter with enable, synchronous clear and a terminal-count
// compare; clear has priority over load, load over increment.
module tpu_phase_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [WIDTH-1:0] i_tc_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_tc_val);

endmodule

// File: rtl/tpu_sequencer.sv
// Job sequencer for a systolic-array TPU: LOAD_W -> COMPUTE -> DRAIN -> DONE.
// Defining TPU_SEQ_WEIGHT_REUSE_EN adds reuse_w, letting a job skip LOAD_W.
module tpu_sequencer
  import tpu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int NUM_OP      = 10,
  parameter int PISO_FULL   = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   stall,
  input  logic                   out_ready,
`ifdef TPU_SEQ_WEIGHT_REUSE_EN
  input  logic                   reuse_w,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   w_load,
  output logic [COUNT_WIDTH-1:0] w_row,
  output logic                   a_valid,
  output logic [COUNT_WIDTH-1:0] a_idx,
  output logic                   acc_clr,
  output logic                   piso_load,
  output logic                   out_valid
);

  localparam int COMPUTE_LEN = NUM_OP + DEPTH - 1;
  localparam int MIN_CW      = $clog2(max3(DEPTH, COMPUTE_LEN, PISO_FULL));

  if (COUNT_WIDTH < MIN_CW) begin : g_cw_check
    $error("tpu_sequencer: COUNT_WIDTH too narrow for DEPTH/NUM_OP/PISO_FULL");
  end

  seq_state_t             r_state;
  logic                   r_acc_pend;
  logic [COUNT_WIDTH-1:0] w_count;
  logic [COUNT_WIDTH-1:0] w_tc_val;
  logic                   w_tc;
  logic                   w_adv;
  logic                   w_leave;
  logic                   w_cnt_clr;
  logic                   w_cnt_en;
  logic                   w_reuse;
  logic                   w_a_phase;

`ifdef TPU_SEQ_WEIGHT_REUSE_EN
  assign w_reuse = reuse_w;
`else
  assign w_reuse = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_tc_val = '0;
    w_adv    = 1'b0;
    case (r_state)
      ST_IDLE:    w_adv = start;
      ST_LOAD_W: begin
        w_tc_val = COUNT_WIDTH'(DEPTH - 1);
        w_adv    = ~stall;
      end
      ST_COMPUTE: begin
        w_tc_val = COUNT_WIDTH'(COMPUTE_LEN - 1);
        w_adv    = ~stall;
      end
      ST_DRAIN: begin
        w_tc_val = COUNT_WIDTH'(PISO_FULL - 1);
        w_adv    = out_ready;
      end
      ST_DONE:    w_adv = 1'b1;
      default:    w_adv = 1'b0;
    endcase
  end

  // IDLE and DONE compare against zero, so one rule covers every phase exit.
  assign w_leave   = w_adv & w_tc;
  assign w_cnt_clr = abort | w_leave;
  assign w_cnt_en  = w_adv & ~w_tc;

  tpu_phase_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_phase_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_cnt_en),
    .i_clr      (w_cnt_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_tc_val   (w_tc_val),
    .o_count    (w_count),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_acc_pend <= 1'b0;
    end else if (abort) begin
      r_state    <= ST_IDLE;
      r_acc_pend <= 1'b0;
    end else begin
      // The clear is owed to the first COMPUTE cycle that is not stalled.
      if (r_state == ST_COMPUTE && !stall) r_acc_pend <= 1'b0;
      if (w_leave) begin
        case (r_state)
          ST_IDLE: begin
            if (w_reuse) begin
              r_state    <= ST_COMPUTE;
              r_acc_pend <= 1'b1;
            end else begin
              r_state    <= ST_LOAD_W;
            end
          end
          ST_LOAD_W: begin
            r_state    <= ST_COMPUTE;
            r_acc_pend <= 1'b1;
          end
          ST_COMPUTE: r_state <= ST_DRAIN;
          ST_DRAIN:   r_state <= ST_DONE;
          default:    r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign w_a_phase = (r_state == ST_COMPUTE) &&
                     ({1'b0, w_count} < (COUNT_WIDTH + 1)'(NUM_OP));

  // busy also acknowledges an accepted start in the same cycle it is sampled.
  assign busy      = (r_state != ST_IDLE) | (start & ~abort & rst_n);
  assign done      = (r_state == ST_DONE);
  assign w_load    = (r_state == ST_LOAD_W);
  assign w_row     = w_load ? w_count : '0;
  assign a_valid   = w_a_phase;
  assign a_idx     = w_a_phase ? w_count : '0;
  assign acc_clr   = (r_state == ST_COMPUTE) & r_acc_pend & ~stall;
  assign piso_load = (r_state == ST_COMPUTE) & w_tc & ~stall;
  assign out_valid = (r_state == ST_DRAIN);

endmodule

// File: tb/tb_tpu_sequencer.sv
// Scoreboard bench for tpu_sequencer: a job-level model predicts each job's
// strobe trace, a monitor rebuilds the observed trace and compares.
`timescale 1ns/1ps
module tb_tpu_sequencer;

  localparam int DEPTH     = 4;
  localparam int NUM_OP    = 10;
  localparam int PISO_FULL = 8;
  localparam int CW        = 4;
  localparam int CLEN      = NUM_OP + DEPTH - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          stall = 1'b0;
  logic          out_ready = 1'b0;
`ifdef TPU_SEQ_WEIGHT_REUSE_EN
  logic          reuse_w = 1'b0;
`endif
  logic          busy, done, w_load, a_valid, acc_clr, piso_load, out_valid;
  logic [CW-1:0] w_row, a_idx;

  tpu_sequencer #(
    .DEPTH       (DEPTH),
    .NUM_OP      (NUM_OP),
    .PISO_FULL   (PISO_FULL),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .stall     (stall),
    .out_ready (out_ready),
`ifdef TPU_SEQ_WEIGHT_REUSE_EN
    .reuse_w   (reuse_w),
`endif
    .busy      (busy),
    .done      (done),
    .w_load    (w_load),
    .w_row     (w_row),
    .a_valid   (a_valid),
    .a_idx     (a_idx),
    .acc_clr   (acc_clr),
    .piso_load (piso_load),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_s(input string name, input string act, input string exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got '%s', expected '%s'", name, act, exp);
    end
  endtask

  typedef struct {
    int busy_len;
    int acc_off;
    int piso_off;
    int done_off;
    int beats;
  } exp_t;

  exp_t  exp_q[$];
  string exp_w_q[$];
  string exp_a_q[$];

  // ---------------- monitor ----------------
  int    m_in_job = 0;
  int    m_off, m_acc_cnt, m_acc_off, m_piso_cnt, m_piso_off;
  int    m_done_cnt, m_done_off, m_beats;
  string m_w, m_a;
  int    off_phase_bad = 0;

  task automatic finalize();
    exp_t  e;
    string ew, ea;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_job: busy for %0d cycles with no job expected", m_off);
      return;
    end
    e  = exp_q.pop_front();
    ew = exp_w_q.pop_front();
    ea = exp_a_q.pop_front();
    check("busy_cycles", m_off, e.busy_len);
    check_s("w_row_seq", m_w, ew);
    check_s("a_idx_seq", m_a, ea);
    check("acc_clr_count", m_acc_cnt, (e.acc_off >= 0) ? 1 : 0);
    check("acc_clr_offset", m_acc_off, e.acc_off);
    check("piso_load_count", m_piso_cnt, (e.piso_off >= 0) ? 1 : 0);
    check("piso_load_offset", m_piso_off, e.piso_off);
    check("done_count", m_done_cnt, (e.done_off >= 0) ? 1 : 0);
    check("done_offset", m_done_off, e.done_off);
    check("beats_accepted", m_beats, e.beats);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_in_job = 0;
    end else begin
      if ((!w_load && w_row != '0) || (!a_valid && a_idx != '0) ||
          (!busy && (done || w_load || a_valid || acc_clr || piso_load || out_valid)))
        off_phase_bad++;
      if (busy) begin
        if (m_in_job == 0) begin
          m_in_job   = 1;
          m_off      = 0;
          m_w        = "";
          m_a        = "";
          m_acc_cnt  = 0;
          m_acc_off  = -1;
          m_piso_cnt = 0;
          m_piso_off = -1;
          m_done_cnt = 0;
          m_done_off = -1;
          m_beats    = 0;
        end
        if (w_load)  m_w = $sformatf("%s%0d,", m_w, w_row);
        if (a_valid) m_a = $sformatf("%s%0d,", m_a, a_idx);
        if (acc_clr) begin
          if (m_acc_cnt == 0) m_acc_off = m_off;
          m_acc_cnt++;
        end
        if (piso_load) begin
          if (m_piso_cnt == 0) m_piso_off = m_off;
          m_piso_cnt++;
        end
        if (done) begin
          if (m_done_cnt == 0) m_done_off = m_off;
          m_done_cnt++;
        end
        if (out_valid && out_ready) m_beats++;
        m_off++;
      end else if (m_in_job != 0) begin
        m_in_job = 0;
        finalize();
      end
    end
  end

  // ---------------- driver + job model ----------------
  // sph: stall phase (0 none, 1 weight load, 2 compute) at step spos for slen
  // cycles; ready_mode: 0 always ready, 1 toggling 1,0,.. from drain start,
  // 2 random; abort_step >= 0 cancels at that compute step; reset_at >= 0
  // pulls rst_n low at that job offset.
  task automatic run_job(input bit reuse, input int sph, input int spos, input int slen,
                         input int abort_step, input int ready_mode, input int reset_at);
    bit    ready[200];
    int    load_len, cstart, comp_len, dstart, beats, last, abort_off, n_cycles;
    bit    st;
    exp_t  e;
    string ws, as;

    load_len = reuse ? 0 : (DEPTH + ((sph == 1) ? slen : 0));
    cstart   = 1 + load_len;
    comp_len = CLEN + ((sph == 2) ? slen : 0);
    dstart   = cstart + comp_len;
    abort_off = (abort_step >= 0) ? cstart + abort_step : -1;

    for (int k = 0; k < 200; k++) begin
      if (ready_mode == 0)      ready[k] = 1'b1;
      else if (ready_mode == 1) ready[k] = (k < dstart) ? 1'b1 : (((k - dstart) % 2) == 0);
      else                      ready[k] = (k >= 80) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    ws = "";
    if (!reuse)
      for (int r = 0; r < DEPTH; r++)
        for (int n = 0; n < 1 + ((sph == 1 && r == spos) ? slen : 0); n++)
          ws = $sformatf("%s%0d,", ws, r);
    as = "";
    for (int s = 0; s < CLEN; s++) begin
      if (abort_step >= 0 && s > abort_step) break;
      if (s < NUM_OP)
        for (int n = 0; n < 1 + ((sph == 2 && s == spos) ? slen : 0); n++)
          as = $sformatf("%s%0d,", as, s);
    end

    e.acc_off = cstart + ((sph == 2 && spos == 0) ? slen : 0);
    if (abort_step >= 0) begin
      e.piso_off = -1;
      e.done_off = -1;
      e.beats    = 0;
      e.busy_len = abort_off + 1;
    end else begin
      e.piso_off = dstart - 1;
      beats = 0;
      last  = dstart;
      for (int k = dstart; beats < PISO_FULL; k++) begin
        if (ready[k]) begin
          beats++;
          last = k;
        end
      end
      e.done_off = last + 1;
      e.busy_len = last + 2;
      e.beats    = PISO_FULL;
    end
    if (reset_at < 0) begin
      exp_q.push_back(e);
      exp_w_q.push_back(ws);
      exp_a_q.push_back(as);
    end

    n_cycles = e.busy_len + 3;
    for (int k = 0; k < n_cycles; k++) begin
      @(posedge clk);
      #1;
      if (sph == 1)      st = (k >= 1 + spos) && (k < 1 + spos + slen);
      else if (sph == 2) st = (k >= cstart + spos) && (k < cstart + spos + slen);
      else               st = 1'b0;
      if (k >= dstart) st = 1'($urandom_range(0, 1));
      start     = (k == 0);
      abort     = (k == abort_off);
      stall     = st;
      out_ready = ready[k];
`ifdef TPU_SEQ_WEIGHT_REUSE_EN
      reuse_w   = reuse;
`endif
      if (k == reset_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'({busy, done, w_load, w_row, a_valid, a_idx,
                                          acc_clr, piso_load, out_valid}), 0);
        start = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset_release", int'(busy), 0);
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rv;
    int sph, spos, slen, ab;

    #1;
    check("reset_outputs_zero", int'({busy, done, w_load, w_row, a_valid, a_idx,
                                      acc_clr, piso_load, out_valid}), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy_after_reset", int'(busy), 0);

    // nominal, stall at weight row 2, backpressure, abort at a_idx 5
    run_job(1'b0, 0, 0, 0, -1, 0, -1);
    run_job(1'b0, 1, 2, 3, -1, 0, -1);
    run_job(1'b0, 0, 0, 0, -1, 1, -1);
    run_job(1'b0, 0, 0, 0, 5, 0, -1);

    // start together with abort in IDLE must not launch a job
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check("start_with_abort_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("start_with_abort_stays_idle", int'(busy), 0);
    end

    // reset mid-drain, then a full nominal job
    run_job(1'b0, 0, 0, 0, -1, 0, 21);
    run_job(1'b0, 0, 0, 0, -1, 0, -1);

`ifdef TPU_SEQ_WEIGHT_REUSE_EN
    run_job(1'b1, 0, 0, 0, -1, 0, -1);
    run_job(1'b1, 2, 0, 2, -1, 2, -1);
`endif

    for (int j = 0; j < 20; j++) begin
      rv   = 1'b0;
`ifdef TPU_SEQ_WEIGHT_REUSE_EN
      rv   = 1'($urandom_range(0, 1));
`endif
      sph  = $urandom_range(0, 2);
      if (rv && sph == 1) sph = 0;
      spos = (sph == 1) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, CLEN - 1);
      slen = $urandom_range(1, 4);
      ab   = (sph != 2 && $urandom_range(0, 4) == 0) ? $urandom_range(0, CLEN - 2) : -1;
      run_job(rv, sph, spos, slen, ab, 2, -1);
    end

    repeat (5) @(negedge clk);
    check("jobs_left_unobserved", exp_q.size(), 0);
    check("off_phase_strobes", off_phase_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
